// File: rtl/mm_pkg.sv
// Shared matrix-multiply constants and the result-reader state encoding.
package mm_pkg;
    localparam int C_DATA_W   = 19;
    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DEPTH  = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO absorbing RAM read data while the output stream is stalled.
module result_skid_fifo #(
    parameter int W = 19
) (
    input  logic         gclk_i,
    input  logic         grst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   cnt_q;

    // Overflow is prevented upstream by the read-issue throttle.
    always_ff @(posedge gclk_i or posedge grst_i) begin
        if (grst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) rd_q <= ~rd_q;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/result_ram_reader.sv
// Streams a block of C result RAM words onto a valid/ready stream,
// hiding the RAM's one-cycle read latency behind a 2-entry buffer.
module result_ram_reader
    import mm_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH
) (
    input  logic              gclk_i,
    input  logic              grst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_rd_o,
    input  logic [DATA_W-1:0] ram_q_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   rem_q, rem_d, idx_q, idx_d, oidx_q, oidx_d;
    logic              inflight_q;
    logic [ADDR_W:0]   len_cl;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic              pop, issue_ok;

    result_skid_fifo #(.W(DATA_W)) u_fifo (
        .gclk_i  (gclk_i),
        .grst_i  (grst_i),
        .push_i  (inflight_q),
        .data_i  (ram_q_i),
        .pop_i   (pop),
        .count_o (fifo_cnt),
        .head_o  (m_data_o)
    );

    assign len_cl    = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign m_valid_o = (fifo_cnt != 2'd0);
    assign pop       = m_valid_o & m_ready_i;
    assign m_last_o  = m_valid_o && (oidx_q == rem_q - ONE);
    // Buffered plus in-flight words, less the one leaving now, must stay below 2.
    assign occ       = {1'b0, fifo_cnt} + {2'b0, inflight_q};
    assign issue_ok  = (occ < 3'd2) || ((occ == 3'd2) && pop);
    assign ram_addr_o = base_q + idx_q[ADDR_W-1:0];
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        oidx_d   = oidx_q + {{ADDR_W{1'b0}}, pop};
        ram_rd_o = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                base_d  = base_i;
                rem_d   = len_cl;
                idx_d   = '0;
                oidx_d  = '0;
                state_d = (len_cl == '0) ? DONE : RUN;
            end
            RUN: if (issue_ok) begin
                ram_rd_o = 1'b1;
                idx_d    = idx_q + ONE;
                if (idx_q == rem_q - ONE) state_d = DRAIN;
            end
            DRAIN: if (pop && m_last_o) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk_i or posedge grst_i) begin
        if (grst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            oidx_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            oidx_q     <= oidx_d;
            inflight_q <= ram_rd_o;
        end
    end
endmodule

// File: tb/tb_result_ram_reader.sv
// Directed/random bench for result_ram_reader with a RAM model and an
// expected-word queue built straight from base/len.
module tb_result_ram_reader;
    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base = '0;
    logic [6:0]  len = '0;
    logic        busy, done, ram_rd, m_valid, m_last;
    logic        m_ready = 1'b0;
    logic [5:0]  ram_addr;
    logic [18:0] ram_q = '0;
    logic [18:0] m_data;
    logic [18:0] mem [64];
    int          checks = 0;
    int          failures = 0;

    always #5 gclk = ~gclk;

    always @(posedge gclk) if (ram_rd) ram_q <= mem[ram_addr];

    result_ram_reader dut (
        .gclk_i(gclk), .grst_i(grst), .start_i(start), .base_i(base), .len_i(len),
        .busy_o(busy), .done_o(done), .ram_addr_o(ram_addr), .ram_rd_o(ram_rd),
        .ram_q_i(ram_q), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_last_o(m_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ram_rd"}, 32'(ram_rd), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_last"}, 32'(m_last), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready.
    // inj >= 0 pulses a conflicting start in that cycle.
    task automatic run(input logic [5:0] b, input logic [6:0] l, input int mode, input int inj);
        logic [18:0] exp_q [$];
        int n, k, issued, cyc, done_cyc;
        logic stall_prev;
        logic [18:0] data_prev;
        n = (int'(l) > 64) ? 64 : int'(l);
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(int'(b) + i) % 64]);
        base = b; len = l; start = 1'b1;
        @(posedge gclk); #1;
        start = 1'b0;
        k = 0; issued = 0; cyc = 0; done_cyc = -1; stall_prev = 1'b0; data_prev = '0;
        while (cyc < 400) begin
            if (cyc == inj) begin
                start = 1'b1; base = b + 6'd17; len = 7'd3;
            end else start = 1'b0;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (stall_prev) begin
                chk("stall_valid", 32'(m_valid), 1);
                chk("stall_data", 32'(m_data), 32'(data_prev));
            end
            if (ram_rd) begin
                chk("ram_addr", 32'(ram_addr), 32'((int'(b) + issued) % 64));
                issued++;
            end
            if (m_valid) chk("m_last", 32'(m_last), 32'(k == n - 1));
            if (m_valid && m_ready) begin
                if (k < n) chk("m_data", 32'(m_data), 32'(exp_q[k]));
                else chk("word_overrun", 32'(k), 32'(n - 1));
                k++;
            end
            chk("occupancy_le2", 32'((issued - k) <= 2), 1);
            chk("busy", 32'(busy), 1);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
            @(posedge gclk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cyc >= 0), 1);
        chk("words_out", 32'(k), 32'(n));
        chk("reads_issued", 32'(issued), 32'(n));
        if (mode == 0) chk("done_cycle", 32'(done_cyc), 32'((n == 0) ? 0 : n + 2));
        @(posedge gclk); #1;
        chk("done_pulse_end", 32'(done), 0);
        chk("busy_end", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 19'(i - 32);
        repeat (2) @(posedge gclk);
        #1;
        chk_reset_outputs("reset");
        grst = 1'b0;
        @(posedge gclk); #1;

        run(6'd0, 7'd64, 0, -1);
        run(6'd60, 7'd8, 0, -1);
        run(6'($urandom), 7'd5, 1, -1);
        run(6'($urandom), 7'd0, 0, -1);
        run(6'($urandom), 7'd100, 0, -1);
        run(6'd20, 7'd10, 0, 2);

        for (int i = 0; i < 64; i++) mem[i] = 19'($urandom);
        for (int t = 0; t < 6; t++)
            run(6'($urandom), 7'($urandom_range(1, 70)), 1 + (t % 2), -1);

        // Park the reader in DRAIN with a word presented, then reset.
        base = 6'd5; len = 7'd2; start = 1'b1; m_ready = 1'b0;
        @(posedge gclk); #1;
        start = 1'b0;
        repeat (4) @(posedge gclk);
        #1;
        chk("pre_reset_valid", 32'(m_valid), 1);
        chk("pre_reset_busy", 32'(busy), 1);
        grst = 1'b1;
        @(posedge gclk); #1;
        chk_reset_outputs("mid_reset");
        grst = 1'b0;
        @(posedge gclk); #1;
        run(6'd62, 7'd7, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
